mii_net_tx_fcs: RTL and testbench
=================================

MII_NET_TX_FCS -- requirements
Module: mii_net_tx_fcs

Interface
REQ-001 Parameter MIN_LEN, default 60, meaning minimum pre-FCS frame length in bytes; 0 disables padding; legal range 0..255.
REQ-002 i_clk  input  1  sole clock; all logic on rising edge.
REQ-003 i_reset_n  input  1  synchronous, active-low reset.
REQ-004 i_data  input  8  payload byte from MAC.
REQ-005 i_valid  input  1  i_data valid.
REQ-006 i_last  input  1  qualifies the final payload byte of a frame.
REQ-007 o_ready  output  1  block accepts i_data this cycle.
REQ-008 o_data  output  8  byte toward MII serializer.
REQ-009 o_valid  output  1  o_data valid.
REQ-010 o_last  output  1  marks the final FCS byte.
REQ-011 i_ready  input  1  downstream accepts o_data this cycle.
REQ-012 o_busy  output  1  high in every state except IDLE.
REQ-013 o_frame_done  output  1  one-cycle pulse on the cycle the last FCS byte is accepted.

Function
REQ-014 Transfer rule: in-side transfer = i_valid & o_ready; out-side transfer = o_valid & i_ready.
REQ-015 FSM states: IDLE, DATA, PAD, FCS.
REQ-016 IDLE/DATA: pass-through; o_data=i_data, o_valid=i_valid, o_ready=i_ready, o_last=0; zero added latency.
REQ-017 IDLE -> DATA on the first in-side transfer; the CRC engine is initialised in IDLE so the first byte is calculated against 0xFFFFFFFF.
REQ-018 Each in-side transfer feeds the byte to the CRC engine with calc=1, valid=1, and increments an 8-bit byte counter that saturates at MIN_LEN.
REQ-019 On an in-side transfer with i_last=1: go to PAD if counter+1 < MIN_LEN, else go to FCS; an i_last on the first byte is legal (1-byte frame).
REQ-020 PAD: o_data=0x00, o_valid=1, o_ready=0; each out-side transfer feeds 0x00 to the CRC with calc=1 and increments the counter; go to FCS when the counter reaches MIN_LEN.
REQ-021 FCS: o_ready=0, o_valid=1, and a 2-bit index counts 0..3. o_data is the CRC byte presented by the engine. Each out-side transfer drives the engine valid=1, calc=0 (8-bit shift).
REQ-022 FCS bytes are the IEEE 802.3 FCS (complemented, bit-reflected CRC-32 over payload+pad), emitted least-significant byte first.
REQ-023 o_last=1 at FCS index 3; on that transfer pulse o_frame_done, init the CRC engine and return to IDLE.
REQ-024 When i_ready=0 in PAD/FCS, o_data, index and CRC state hold; the engine sees valid=0.
REQ-025 The engine is never driven with valid=1 in a cycle without a corresponding transfer.
REQ-026 i_valid while not in IDLE/DATA is back-pressured (o_ready=0), never dropped.

Reset
REQ-027 On i_reset_n=0 at a clock edge: state=IDLE, counters=0, CRC engine init (0xFFFFFFFF), o_valid=0, o_last=0, o_busy=0, o_frame_done=0; o_ready follows i_ready.
REQ-028 Reset mid-frame (any state) abandons the frame; no FCS is emitted, and the next frame starts clean.

Structure
REQ-029 Shared package mii_net_pkg SHALL hold the state enum type, FCS_LEN=4, and the default MIN_LEN=60.
REQ-030 Exactly one sub-module SHALL be instantiated: mii_net_crc32, with its active-high reset tied to ~i_reset_n and its init/calc/valid driven only by this FSM.

Verification
REQ-031 MIN_LEN=0, payload ASCII "123456789", i_ready=1 -> output is 13 bytes, last four 0x26 0x39 0xF4 0xCB, o_last on byte 13, one o_frame_done pulse.
REQ-032 MIN_LEN=60, 14-byte payload -> 46 bytes 0x00 then 4 FCS bytes (64 total); FCS matches a software CRC-32 model over the 60 bytes.
REQ-033 MIN_LEN=0, "123456789" with i_ready randomly low 50% of cycles -> identical 13-byte output; no byte duplicated or skipped.
REQ-034 MIN_LEN=60, 1-byte frame 0xAB with i_last on the first byte -> 0xAB, 59x 0x00, 4 FCS bytes; o_busy high throughout, low the cycle after o_frame_done.
REQ-035 Reset asserted during FCS index 1 -> outputs reach reset values next cycle; the following "123456789" frame (MIN_LEN=0) again ends 0x26 0x39 0xF4 0xCB.
REQ-036 Two back-to-back 60-byte frames with i_valid held high -> o_ready=0 during each FCS phase; the second frame's first byte is accepted the cycle after the first o_frame_done, and both FCS values are correct.

Source files
------------

// File: rtl/mii_net_pkg.sv
// Shared types and constants for the MII transmit FCS path: FSM state encoding,
// frame constants and the bytewise reflected CRC-32 step.
package mii_net_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAD  = 2'd2,
        ST_FCS  = 2'd3
    } state_e;

    localparam int          FCS_LEN         = 4;
    localparam int          MIN_LEN_DEFAULT = 60;
    localparam logic [31:0] CRC_INIT        = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY_REFL   = 32'hEDB8_8320;

    // One byte of the LSB-first (reflected) CRC-32 update.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/mii_net_crc32.sv
// Reflected CRC-32 engine: calc=1 folds a byte into the CRC, calc=0 shifts the
// register right by one byte so byte_o walks through the FCS LSB first.
module mii_net_crc32
    import mii_net_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       init_i,
    input  logic       calc_i,
    input  logic       valid_i,
    input  logic [7:0] data_i,
    output logic [7:0] byte_o
);

    logic [31:0] crc_q, crc_d, crc_base;

    // init may coincide with valid; the operation then starts from the seed.
    always_comb begin
        crc_base = init_i ? CRC_INIT : crc_q;
        crc_d    = crc_q;
        if (valid_i) begin
            crc_d = calc_i ? crc32_byte(crc_base, data_i) : {8'hFF, crc_base[31:8]};
        end else if (init_i) begin
            crc_d = CRC_INIT;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign byte_o = ~crc_q[7:0];

endmodule

// File: rtl/mii_net_tx_fcs.sv
// Transmit framer between MAC and MII serializer: passes payload through,
// zero-pads short frames to MIN_LEN bytes and appends the 4-byte Ethernet FCS.
module mii_net_tx_fcs
    import mii_net_pkg::*;
#(
    parameter int MIN_LEN = MIN_LEN_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    input  logic       i_last,
    output logic       o_ready,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_last,
    input  logic       i_ready,
    output logic       o_busy,
    output logic       o_frame_done
);

    // Both sides use valid/ready: a byte moves only in a cycle where valid and
    // ready are both high; valid and data never depend on the receiver's ready
    // except in IDLE/DATA, where the block is a zero-latency wire.

    localparam logic [8:0] MIN_LEN_W = 9'(MIN_LEN);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [8:0]  cnt_inc;
    logic        fcs_last;
    logic        crc_init, crc_calc, crc_valid;
    logic [7:0]  crc_data, crc_byte;

    assign cnt_inc  = {1'b0, cnt_q} + 9'd1;
    assign fcs_last = (idx_q == 2'(FCS_LEN - 1));
    assign o_busy   = (state_q != ST_IDLE);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        o_data       = i_data;
        o_valid      = i_valid;
        o_ready      = i_ready;
        o_last       = 1'b0;
        o_frame_done = 1'b0;
        crc_init     = 1'b0;
        crc_calc     = 1'b0;
        crc_valid    = 1'b0;
        crc_data     = i_data;
        case (state_q)
            ST_IDLE, ST_DATA: begin
                crc_init = (state_q == ST_IDLE);
                if (i_valid && i_ready) begin
                    crc_valid = 1'b1;
                    crc_calc  = 1'b1;
                    if (cnt_inc <= MIN_LEN_W) begin
                        cnt_d = cnt_inc[7:0];
                    end
                    state_d = ST_DATA;
                    if (i_last) begin
                        state_d = (cnt_inc < MIN_LEN_W) ? ST_PAD : ST_FCS;
                    end
                end
            end
            ST_PAD: begin
                o_data   = 8'h00;
                o_valid  = 1'b1;
                o_ready  = 1'b0;
                crc_data = 8'h00;
                if (i_ready) begin
                    crc_valid = 1'b1;
                    crc_calc  = 1'b1;
                    cnt_d     = cnt_inc[7:0];
                    if (cnt_inc >= MIN_LEN_W) begin
                        state_d = ST_FCS;
                    end
                end
            end
            ST_FCS: begin
                o_data  = crc_byte;
                o_valid = 1'b1;
                o_ready = 1'b0;
                o_last  = fcs_last;
                if (i_ready) begin
                    crc_valid = 1'b1;
                    idx_d     = idx_q + 2'd1;
                    if (fcs_last) begin
                        o_frame_done = 1'b1;
                        crc_init     = 1'b1;
                        cnt_d        = 8'd0;
                        idx_d        = 2'd0;
                        state_d      = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    mii_net_crc32 u_crc (
        .clk_i   (i_clk),
        .rst_i   (~i_reset_n),
        .init_i  (crc_init),
        .calc_i  (crc_calc),
        .valid_i (crc_valid),
        .data_i  (crc_data),
        .byte_o  (crc_byte)
    );

endmodule

// File: tb/tb_mii_net_tx_fcs.sv
// Directed bench for mii_net_tx_fcs: one instance with padding off, one with
// MIN_LEN=60; a negedge monitor records every output byte and handshake event.
module tb_mii_net_tx_fcs;

    logic       clk        = 1'b0;
    logic       i_reset_n  = 1'b0;
    logic [7:0] i_data     = 8'h00;
    logic       i_valid    = 1'b0;
    logic       i_last     = 1'b0;
    logic       i_ready    = 1'b1;
    logic       sel        = 1'b0;
    logic       ready_mode = 1'b0;

    int checks     = 0;
    int fails      = 0;
    int cyc        = 0;
    int tail_start = 1000;
    int busy_err   = 0;
    int tail_err   = 0;
    int out_idx    = 0;
    logic in_frame = 1'b0;

    logic [7:0] obs_q[$];
    logic       last_q[$];
    int         in_cyc_q[$];
    int         done_cyc_q[$];

    logic       a_o_ready, a_o_valid, a_o_last, a_o_busy, a_o_frame_done;
    logic [7:0] a_o_data;
    logic       b_o_ready, b_o_valid, b_o_last, b_o_busy, b_o_frame_done;
    logic [7:0] b_o_data;
    logic       s_o_ready, s_o_valid, s_o_last, s_o_busy, s_o_frame_done;
    logic [7:0] s_o_data;

    mii_net_tx_fcs #(.MIN_LEN(0)) dut_a (
        .i_clk(clk), .i_reset_n(i_reset_n), .i_data(i_data), .i_valid(i_valid),
        .i_last(i_last), .o_ready(a_o_ready), .o_data(a_o_data), .o_valid(a_o_valid),
        .o_last(a_o_last), .i_ready(i_ready), .o_busy(a_o_busy), .o_frame_done(a_o_frame_done)
    );

    mii_net_tx_fcs #(.MIN_LEN(60)) dut_b (
        .i_clk(clk), .i_reset_n(i_reset_n), .i_data(i_data), .i_valid(i_valid),
        .i_last(i_last), .o_ready(b_o_ready), .o_data(b_o_data), .o_valid(b_o_valid),
        .o_last(b_o_last), .i_ready(i_ready), .o_busy(b_o_busy), .o_frame_done(b_o_frame_done)
    );

    assign s_o_ready      = sel ? b_o_ready      : a_o_ready;
    assign s_o_valid      = sel ? b_o_valid      : a_o_valid;
    assign s_o_last       = sel ? b_o_last       : a_o_last;
    assign s_o_busy       = sel ? b_o_busy       : a_o_busy;
    assign s_o_frame_done = sel ? b_o_frame_done : a_o_frame_done;
    assign s_o_data       = sel ? b_o_data       : a_o_data;

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        i_ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Monitor: at negedge the inputs are stable until the next posedge, so a
    // valid&ready seen here is the transfer of the coming edge.
    always @(negedge clk) begin
        if (!i_reset_n) begin
            out_idx  = 0;
            in_frame = 1'b0;
        end else begin
            if (in_frame && !s_o_busy) busy_err++;
            if (s_o_valid && out_idx >= tail_start && s_o_ready) tail_err++;
            if (s_o_valid && i_ready) begin
                obs_q.push_back(s_o_data);
                last_q.push_back(s_o_last);
                out_idx = s_o_last ? 0 : out_idx + 1;
            end
            if (i_valid && s_o_ready) begin
                in_cyc_q.push_back(cyc);
                in_frame = 1'b1;
            end
            if (s_o_frame_done) begin
                done_cyc_q.push_back(cyc);
                in_frame = 1'b0;
            end
        end
    end

    // driver tasks
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        i_valid   = 1'b0;
        i_last    = 1'b0;
        i_reset_n = 1'b0;
        tick;
        tick;
        i_reset_n = 1'b1;
        tick;
    endtask

    task automatic drive_stream(input logic [7:0] b[$], input logic l[$]);
        int k     = 0;
        int guard = 0;
        while (k < b.size() && guard < 4000) begin
            i_valid = 1'b1;
            i_data  = b[k];
            i_last  = l[k];
            @(negedge clk);
            if (s_o_ready) k++;
            tick;
            guard++;
        end
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_data  = 8'h00;
        checks++;
        if (k < b.size()) begin
            fails++;
            $display("FAIL drive_timeout: accepted %0d bytes, required %0d", k, b.size());
        end
    endtask

    task automatic wait_done(input int target);
        int g = 0;
        while (done_cyc_q.size() < target && g < 2000) begin
            tick;
            g++;
        end
    endtask

    // Reference FCS: MSB-first register with LSB-first bit feed, then
    // reflected and complemented.
    function automatic logic [31:0] fcs_model(input logic [7:0] b[$]);
        logic [31:0] c, r;
        logic        fb;
        c = 32'hFFFF_FFFF;
        foreach (b[k]) begin
            for (int i = 0; i < 8; i++) begin
                fb = c[31] ^ b[k][i];
                c  = {c[30:0], 1'b0};
                if (fb) c = c ^ 32'h04C1_1DB7;
            end
        end
        for (int i = 0; i < 32; i++) r[i] = c[31 - i];
        return ~r;
    endfunction

    task automatic test_reset;
        i_reset_n = 1'b0;
        i_valid   = 1'b0;
        tick;
        tick;
        checks++;
        if ({a_o_valid, a_o_last, a_o_busy, a_o_frame_done} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_a_outputs: got %b, required 0000", {a_o_valid, a_o_last, a_o_busy, a_o_frame_done});
        end
        checks++;
        if ({b_o_valid, b_o_last, b_o_busy, b_o_frame_done} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_b_outputs: got %b, required 0000", {b_o_valid, b_o_last, b_o_busy, b_o_frame_done});
        end
        checks++;
        if (a_o_ready !== 1'b1 || b_o_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: got %b%b, required 11", a_o_ready, b_o_ready);
        end
        i_reset_n = 1'b1;
        tick;
    endtask

    task automatic test_check_value(input string name, input logic rnd);
        logic [7:0] pay[$];
        logic       pl[$];
        logic [7:0] exp_q[$];
        int b0, d0;
        do_reset;
        sel = 1'b0;
        ready_mode = rnd;
        b0 = obs_q.size();
        d0 = done_cyc_q.size();
        for (int i = 0; i < 9; i++) begin
            pay.push_back(8'h31 + 8'(i));
            pl.push_back(i == 8);
            exp_q.push_back(8'h31 + 8'(i));
        end
        exp_q.push_back(8'h26); exp_q.push_back(8'h39);
        exp_q.push_back(8'hF4); exp_q.push_back(8'hCB);
        drive_stream(pay, pl);
        wait_done(d0 + 1);
        ready_mode = 1'b0;
        repeat (4) tick;
        checks++;
        if (obs_q.size() - b0 !== exp_q.size()) begin
            fails++;
            $display("FAIL %s_len: got %0d bytes, required %0d", name, obs_q.size() - b0, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && b0 + i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[b0 + i] !== exp_q[i] || last_q[b0 + i] !== (i == exp_q.size() - 1)) begin
                fails++;
                $display("FAIL %s_byte[%0d]: got %h last=%b, required %h last=%b", name, i,
                         obs_q[b0 + i], last_q[b0 + i], exp_q[i], (i == exp_q.size() - 1));
            end
        end
        checks++;
        if (done_cyc_q.size() - d0 !== 1) begin
            fails++;
            $display("FAIL %s_done: got %0d pulses, required 1", name, done_cyc_q.size() - d0);
        end
    endtask

    task automatic test_padded(input string name, input int n_pay);
        logic [7:0] pay[$];
        logic       pl[$];
        logic [7:0] f60[$];
        logic [7:0] exp_q[$];
        logic [31:0] fcs;
        int b0, d0, be0;
        do_reset;
        sel = 1'b1;
        b0  = obs_q.size();
        d0  = done_cyc_q.size();
        be0 = busy_err;
        for (int i = 0; i < n_pay; i++) begin
            pay.push_back((n_pay == 1) ? 8'hAB : 8'h10 + 8'(i * 7));
            pl.push_back(i == n_pay - 1);
        end
        f60 = pay;
        while (f60.size() < 60) f60.push_back(8'h00);
        fcs = fcs_model(f60);
        exp_q = f60;
        exp_q.push_back(fcs[7:0]);   exp_q.push_back(fcs[15:8]);
        exp_q.push_back(fcs[23:16]); exp_q.push_back(fcs[31:24]);
        drive_stream(pay, pl);
        wait_done(d0 + 1);
        checks++;
        if (s_o_busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_busy_after: got %b, required 0", name, s_o_busy);
        end
        repeat (3) tick;
        checks++;
        if (obs_q.size() - b0 !== 64) begin
            fails++;
            $display("FAIL %s_len: got %0d bytes, required 64", name, obs_q.size() - b0);
        end
        for (int i = 0; i < 64 && b0 + i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[b0 + i] !== exp_q[i] || last_q[b0 + i] !== (i == 63)) begin
                fails++;
                $display("FAIL %s_byte[%0d]: got %h last=%b, required %h last=%b", name, i,
                         obs_q[b0 + i], last_q[b0 + i], exp_q[i], (i == 63));
            end
        end
        checks++;
        if (busy_err - be0 !== 0) begin
            fails++;
            $display("FAIL %s_busy_during: got %0d idle cycles mid-frame, required 0", name, busy_err - be0);
        end
        checks++;
        if (done_cyc_q.size() - d0 !== 1) begin
            fails++;
            $display("FAIL %s_done: got %0d pulses, required 1", name, done_cyc_q.size() - d0);
        end
    endtask

    task automatic test_reset_mid_fcs;
        logic [7:0] pay[$];
        logic       pl[$];
        int d0;
        do_reset;
        sel = 1'b0;
        d0  = done_cyc_q.size();
        for (int i = 0; i < 9; i++) begin
            pay.push_back(8'h31 + 8'(i));
            pl.push_back(i == 8);
        end
        drive_stream(pay, pl);
        tick;
        checks++;
        if (a_o_valid !== 1'b1 || a_o_data !== 8'h39) begin
            fails++;
            $display("FAIL rst_fcs_idx1: got valid=%b data=%h, required 1/39", a_o_valid, a_o_data);
        end
        i_reset_n = 1'b0;
        tick;
        checks++;
        if ({a_o_valid, a_o_last, a_o_busy, a_o_frame_done, a_o_ready} !== 5'b00001) begin
            fails++;
            $display("FAIL rst_fcs_outputs: got %b, required 00001",
                     {a_o_valid, a_o_last, a_o_busy, a_o_frame_done, a_o_ready});
        end
        checks++;
        if (done_cyc_q.size() - d0 !== 0) begin
            fails++;
            $display("FAIL rst_fcs_no_done: got %0d pulses, required 0", done_cyc_q.size() - d0);
        end
        i_reset_n = 1'b1;
        tick;
        test_check_value("after_rst", 1'b0);
    endtask

    task automatic test_back_to_back;
        logic [7:0] pay[$];
        logic       pl[$];
        logic [7:0] fa[$];
        logic [7:0] fb[$];
        logic [7:0] exp_q[$];
        logic       exp_l[$];
        logic [31:0] fcs_a, fcs_b;
        int b0, d0, i0, te0;
        do_reset;
        sel = 1'b1;
        tail_start = 60;
        b0  = obs_q.size();
        d0  = done_cyc_q.size();
        i0  = in_cyc_q.size();
        te0 = tail_err;
        for (int i = 0; i < 60; i++) begin
            fa.push_back(8'(i * 3 + 1));
            fb.push_back(8'hFF - 8'(i));
        end
        fcs_a = fcs_model(fa);
        fcs_b = fcs_model(fb);
        for (int i = 0; i < 120; i++) begin
            pay.push_back(i < 60 ? fa[i] : fb[i - 60]);
            pl.push_back(i == 59 || i == 119);
        end
        exp_q = fa;
        exp_q.push_back(fcs_a[7:0]);   exp_q.push_back(fcs_a[15:8]);
        exp_q.push_back(fcs_a[23:16]); exp_q.push_back(fcs_a[31:24]);
        foreach (fb[i]) exp_q.push_back(fb[i]);
        exp_q.push_back(fcs_b[7:0]);   exp_q.push_back(fcs_b[15:8]);
        exp_q.push_back(fcs_b[23:16]); exp_q.push_back(fcs_b[31:24]);
        foreach (exp_q[i]) exp_l.push_back(i == 63 || i == 127);
        drive_stream(pay, pl);
        wait_done(d0 + 2);
        repeat (3) tick;
        tail_start = 1000;
        checks++;
        if (obs_q.size() - b0 !== 128) begin
            fails++;
            $display("FAIL b2b_len: got %0d bytes, required 128", obs_q.size() - b0);
        end
        for (int i = 0; i < 128 && b0 + i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[b0 + i] !== exp_q[i] || last_q[b0 + i] !== exp_l[i]) begin
                fails++;
                $display("FAIL b2b_byte[%0d]: got %h last=%b, required %h last=%b", i,
                         obs_q[b0 + i], last_q[b0 + i], exp_q[i], exp_l[i]);
            end
        end
        checks++;
        if (tail_err - te0 !== 0) begin
            fails++;
            $display("FAIL b2b_ready_in_fcs: got %0d cycles with o_ready=1, required 0", tail_err - te0);
        end
        checks++;
        if (done_cyc_q.size() - d0 !== 2) begin
            fails++;
            $display("FAIL b2b_done: got %0d pulses, required 2", done_cyc_q.size() - d0);
        end
        if (done_cyc_q.size() > d0 && in_cyc_q.size() > i0 + 60) begin
            checks++;
            if (in_cyc_q[i0 + 60] - done_cyc_q[d0] !== 1) begin
                fails++;
                $display("FAIL b2b_second_start: got %0d cycles after done, required 1",
                         in_cyc_q[i0 + 60] - done_cyc_q[d0]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_check_value("check_value", 1'b0);
        test_padded("pad14", 14);
        test_check_value("backpressure", 1'b1);
        test_padded("one_byte", 1);
        test_reset_mid_fcs;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
